// File: rtl/locked_adder_pkg.sv
// Shared types and defaults for the locked-adder key sequencer / arbiter.
package locked_adder_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int KEY_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN_IDLE = 3'd2,
    RUN_EXEC = 3'd3,
    RUN_RESP = 3'd4
  } state_e;

  // Bit counter must be able to hold the value key_w itself.
  function automatic int key_cnt_w(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer records the last granted index.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] vld,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q;

  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    case (vld)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    if (vld != 2'b00) gnt = gnt_id ? 2'b10 : 2'b01;
  end

  // Reset pointer of 1 lets requester 0 win the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      last_q <= 1'b1;
    else if (advance) last_q <= gnt_id;
  end

endmodule

// File: rtl/locked_adder_key_sched.sv
// Serial key loader plus round-robin front end for one combinational locked adder.
// Optional zeroize input key_clear_i is built when LOCKED_ADDER_KEY_ZEROIZE_EN is defined.
module locked_adder_key_sched
  import locked_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_start_i,
  input  logic             key_bit_i,
  input  logic             key_bit_vld_i,
`ifdef LOCKED_ADDER_KEY_ZEROIZE_EN
  input  logic             key_clear_i,
`endif
  output logic             key_locked_o,
  input  logic             req0_vld_i,
  output logic             req0_rdy_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_vld_i,
  output logic             req1_rdy_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_vld_o,
  input  logic             rsp_rdy_i,
  output logic             rsp_id_o,
  output logic [WIDTH:0]   rsp_sum_o,
  output logic [WIDTH-1:0] adder_a_o,
  output logic [WIDTH-1:0] adder_b_o,
  output logic [KEY_W-1:0] adder_key_o,
  input  logic [WIDTH:0]   adder_sum_i,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where vld and rdy are both high;
  // a requester keeps vld and its operands stable until that edge, rdy never waits on
  // anything but state, grant, key_start_i and zeroize.

  localparam int CNT_W = key_cnt_w(KEY_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             clr;
  logic             can_accept;
  logic             load_clr;
  logic             last_bit;
  logic [1:0]       arb_vld;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             hs;

`ifdef LOCKED_ADDER_KEY_ZEROIZE_EN
  assign clr = key_clear_i;
`else
  assign clr = 1'b0;
`endif

  assign can_accept  = (state_q == RUN_IDLE) && !key_start_i && !clr;
  assign arb_vld     = {req1_vld_i, req0_vld_i} & {2{can_accept}};
  assign hs          = |gnt;
  assign req0_rdy_o  = gnt[0];
  assign req1_rdy_o  = gnt[1];
  assign last_bit    = (cnt_q == CNT_W'(KEY_W - 1));
  assign dbg_state_o = state_q;

  // key_start_i is only honoured while no transaction is in flight.
  assign load_clr = key_start_i &&
                    ((state_q == IDLE) || (state_q == LOAD) || (state_q == RUN_IDLE));

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .vld     (arb_vld),
    .advance (hs),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (key_start_i) state_d = LOAD;
      LOAD:     if (!key_start_i && key_bit_vld_i && last_bit) state_d = RUN_IDLE;
      RUN_IDLE: begin
        if (key_start_i) state_d = LOAD;
        else if (hs)     state_d = RUN_EXEC;
      end
      RUN_EXEC: state_d = RUN_RESP;
      RUN_RESP: if (rsp_rdy_i) state_d = RUN_IDLE;
      default:  state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      adder_key_o  <= '0;
      key_locked_o <= 1'b1;
      adder_a_o    <= '0;
      adder_b_o    <= '0;
      rsp_vld_o    <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_sum_o    <= '0;
    end else if (clr) begin
      cnt_q        <= '0;
      adder_key_o  <= '0;
      key_locked_o <= 1'b1;
      adder_a_o    <= '0;
      adder_b_o    <= '0;
      rsp_vld_o    <= 1'b0;
    end else begin
      if (load_clr) begin
        cnt_q        <= '0;
        adder_key_o  <= '0;
        key_locked_o <= 1'b1;
      end else if (state_q == LOAD && key_bit_vld_i) begin
        adder_key_o <= {adder_key_o[KEY_W-2:0], key_bit_i};
        cnt_q       <= cnt_q + 1'b1;
        if (last_bit) key_locked_o <= 1'b0;
      end

      if (hs) begin
        adder_a_o <= gnt_id ? req1_a_i : req0_a_i;
        adder_b_o <= gnt_id ? req1_b_i : req0_b_i;
        rsp_id_o  <= gnt_id;
      end

      // The adder settles during RUN_EXEC; its result is captured at the end of it.
      if (state_q == RUN_EXEC) begin
        rsp_sum_o <= adder_sum_i;
        rsp_vld_o <= 1'b1;
      end else if (state_q == RUN_RESP && rsp_rdy_i) begin
        rsp_vld_o <= 1'b0;
      end
    end
  end

endmodule
